// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: walks active-low columns, classifies each frame,
// and debounces single-key presses and releases over whole frames.
module keypad_scanner #(
    parameter int NROWS    = 4,
    parameter int NCOLS    = 4,
    parameter int SETTLE   = 2,
    parameter int DEBOUNCE = 3,
    parameter int KEYW     = $clog2(NROWS * NCOLS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [NROWS-1:0] row_in,
    output logic [NCOLS-1:0] col_drive,
    output logic [KEYW-1:0]  key,
    output logic             key_valid,
    output logic             key_release,
    output logic             key_held,
    output logic             multi_key
);

    localparam int COLW  = $clog2(NCOLS);
    localparam int SLOTW = $clog2(SETTLE + 1);
    localparam int CNTW  = $clog2(DEBOUNCE + 1);
    localparam int ROWW  = $clog2(NROWS);

    typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_HELD, S_RELEASE} state_t;

    state_t           state;
    logic             active;
    logic [COLW-1:0]  col;
    logic [COLW-1:0]  col_next;
    logic [SLOTW-1:0] slot;
    logic [CNTW-1:0]  cnt;
    logic [KEYW-1:0]  cand;
    logic [1:0]       acc_hits;
    logic [KEYW-1:0]  acc_code;

    logic [1:0]       col_hits;
    logic [ROWW-1:0]  hit_row;
    logic [2:0]       hit_sum;
    logic [1:0]       frame_hits;
    logic [KEYW-1:0]  frame_code;
    logic             sample;
    logic             frame_end;
    logic             single;
    logic             cnt_done;

    // Closures are counted saturating at 2; only the first one's code matters.
    always_comb begin
        col_hits = '0;
        hit_row  = '0;
        for (int unsigned r = 0; r < NROWS; r++) begin
            if (!row_in[r]) begin
                if (col_hits == 2'd0) hit_row = ROWW'(r);
                if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
            end
        end
        hit_sum    = {1'b0, acc_hits} + {1'b0, col_hits};
        frame_hits = (hit_sum > 3'd2) ? 2'd2 : hit_sum[1:0];
        frame_code = (acc_hits != 2'd0) ? acc_code
                                        : KEYW'(int'(hit_row) * NCOLS + int'(col));
    end

    assign sample    = active && (slot == SLOTW'(SETTLE - 1));
    assign frame_end = sample && (col == COLW'(NCOLS - 1));
    assign col_next  = (col == COLW'(NCOLS - 1)) ? '0 : col + COLW'(1);
    assign single    = (frame_hits == 2'd1);
    assign cnt_done  = (int'(cnt) + 1 >= DEBOUNCE);
    assign key_held  = (state == S_HELD) || (state == S_RELEASE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            active      <= 1'b0;
            col         <= '0;
            slot        <= '0;
            cnt         <= '0;
            cand        <= '0;
            acc_hits    <= '0;
            acc_code    <= '0;
            col_drive   <= '1;
            key         <= '0;
            key_valid   <= 1'b0;
            key_release <= 1'b0;
            multi_key   <= 1'b0;
        end else begin
            key_valid   <= 1'b0;
            key_release <= 1'b0;
            if (!enable) begin
                state     <= S_IDLE;
                active    <= 1'b0;
                col       <= '0;
                slot      <= '0;
                cnt       <= '0;
                acc_hits  <= '0;
                acc_code  <= '0;
                col_drive <= '1;
            end else if (!active) begin
                active    <= 1'b1;
                col       <= '0;
                slot      <= '0;
                col_drive <= ~NCOLS'(1);
            end else if (!sample) begin
                slot <= slot + SLOTW'(1);
            end else begin
                slot      <= '0;
                col       <= col_next;
                col_drive <= ~(NCOLS'(1) << col_next);
                if (!frame_end) begin
                    acc_hits <= frame_hits;
                    acc_code <= frame_code;
                end else begin
                    acc_hits  <= '0;
                    acc_code  <= '0;
                    multi_key <= (frame_hits == 2'd2);
                    case (state)
                        S_IDLE: begin
                            if (single) begin
                                cand <= frame_code;
                                if (DEBOUNCE <= 1) begin
                                    state     <= S_HELD;
                                    key       <= frame_code;
                                    key_valid <= 1'b1;
                                    cnt       <= '0;
                                end else begin
                                    state <= S_DEBOUNCE;
                                    cnt   <= CNTW'(1);
                                end
                            end
                        end
                        S_DEBOUNCE: begin
                            if (single && frame_code == cand) begin
                                if (cnt_done) begin
                                    state     <= S_HELD;
                                    key       <= cand;
                                    key_valid <= 1'b1;
                                    cnt       <= '0;
                                end else begin
                                    cnt <= cnt + CNTW'(1);
                                end
                            end else begin
                                state <= S_IDLE;
                                cnt   <= '0;
                            end
                        end
                        S_HELD: begin
                            if (!(single && frame_code == key)) begin
                                if (DEBOUNCE <= 1) begin
                                    state       <= S_IDLE;
                                    key_release <= 1'b1;
                                    cnt         <= '0;
                                end else begin
                                    state <= S_RELEASE;
                                    cnt   <= CNTW'(1);
                                end
                            end
                        end
                        S_RELEASE: begin
                            if (single && frame_code == key) begin
                                state <= S_HELD;
                                cnt   <= '0;
                            end else if (cnt_done) begin
                                state       <= S_IDLE;
                                key_release <= 1'b1;
                                cnt         <= '0;
                            end else begin
                                cnt <= cnt + CNTW'(1);
                            end
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end
        end
    end

endmodule
